// File: rtl/sdm_cic_dec.sv
// Second-order decimating CIC for the sigma-delta bit stream.
// Emits signed PCM samples through a one-deep full/pop-toggle output register.
module sdm_cic_dec #(
    parameter int RLOG = 3,
    parameter int DMSB = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            setn,
    input  logic            stb,
    input  logic            din,
    input  logic            pop,
    input  logic            clear,
    output logic [DMSB:0]   rdata,
    output logic            full,
    output logic            ovf,
    output logic [RLOG-1:0] cst
);

    localparam int W  = 2 * RLOG + 2;
    localparam int SH = 2 * RLOG - DMSB;
    localparam logic [W-1:0]  QPOS = W'(2 ** DMSB);
    localparam logic [DMSB:0] OMAX = {1'b0, {DMSB{1'b1}}};

    logic signed [W-1:0] i1, i2, d1, d2, v, c1;
    logic signed [W-1:0] x, i1_n, i2_n, c2, q_w;
    logic                v_vld, c1_vld, pop_d;
    logic                dec, pop_ev, sat;
    logic [DMSB:0]       q;

    always_comb begin
        x      = din ? W'(1) : {W{1'b1}};
        i1_n   = i1 + x;
        i2_n   = i2 + i1_n;
        dec    = stb && (cst == {RLOG{1'b1}});
        c2     = c1 - d2;
        q_w    = c2 >>> SH;
        // Only +full-scale can exceed the signed output range.
        sat    = (q_w == QPOS);
        q      = sat ? OMAX : q_w[DMSB:0];
        pop_ev = (pop != pop_d);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i1 <= '0; i2 <= '0; d1 <= '0; d2 <= '0;
            v <= '0; c1 <= '0; v_vld <= 1'b0; c1_vld <= 1'b0;
            cst <= '0; pop_d <= 1'b0;
            rdata <= '0; full <= 1'b0; ovf <= 1'b0;
        end else if (!setn) begin
            i1 <= '0; i2 <= '0; d1 <= '0; d2 <= '0;
            v <= '0; c1 <= '0; v_vld <= 1'b0; c1_vld <= 1'b0;
            cst <= '0; pop_d <= 1'b0;
            rdata <= '0; full <= 1'b0; ovf <= 1'b0;
        end else begin
            pop_d <= pop;
            if (clear) begin
                i1 <= '0; i2 <= '0; d1 <= '0; d2 <= '0;
                v <= '0; c1 <= '0; v_vld <= 1'b0; c1_vld <= 1'b0;
                cst <= '0; full <= 1'b0; ovf <= 1'b0;
            end else begin
                if (stb) begin
                    i1  <= i1_n;
                    i2  <= i2_n;
                    cst <= cst + RLOG'(1);
                end
                v_vld <= dec;
                if (dec)
                    v <= i2_n;
                c1_vld <= v_vld;
                if (v_vld) begin
                    c1 <= v - d1;
                    d1 <= v;
                end
                if (c1_vld) begin
                    d2 <= c1;
                    // A pop in the load cycle frees the slot for this sample.
                    if (!full || pop_ev) begin
                        rdata <= q;
                        full  <= 1'b1;
                    end else begin
                        ovf <= 1'b1;
                    end
                end else if (pop_ev) begin
                    full <= 1'b0;
                end
            end
        end
    end

endmodule
